// File: rtl/pl_id_scoreboard.sv
// pl_id_scoreboard: decode-stage hazard, forwarding and stall controller.
//
// Tracks in-flight register writes in a DEPTH-slot shift array (slot 0 = E,
// slot 1 = M, ...). A separate per-register pending table covers a single
// variable-latency long-operation unit (mul/div). From the current state
// and the ID-stage instruction it combinationally produces the operand
// forwarding selects, the stall/PC-IR write enable and the issue strobe.
//
// Ports:
//   clk, clr        clock, synchronous active-high reset
//   dvalid, dflush  ID holds a valid instruction / instruction in ID is killed
//   rs1, rs2        source registers; duse1/duse2 mark them as actually read
//   rd, dwreg       destination register and its write enable
//   drdy            first slot index at which the result can be forwarded
//   dlat            0 = pipeline op, L>0 = long op completing after L cycles
//   stall, wpcir    hold PC/IR and inject a bubble; wpcir = ~stall
//   issue           instruction leaves ID this cycle
//   fwda, fwdb      0 = regfile, k+1 = slot k, DEPTH+1 = long-unit result
//   lbusy, lwb, lrd long unit occupied / writing back now / its destination
module pl_id_scoreboard #(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned NREG  = 32,
  parameter int unsigned LATW  = 5,
  parameter int unsigned FW    = $clog2(DEPTH + 2)
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       dvalid,
  input  logic                       dflush,
  input  logic [4:0]                 rs1,
  input  logic [4:0]                 rs2,
  input  logic                       duse1,
  input  logic                       duse2,
  input  logic [4:0]                 rd,
  input  logic                       dwreg,
  input  logic [$clog2(DEPTH)-1:0]   drdy,
  input  logic [LATW-1:0]            dlat,
  output logic                       stall,
  output logic                       wpcir,
  output logic                       issue,
  output logic [FW-1:0]              fwda,
  output logic [FW-1:0]              fwdb,
  output logic                       lbusy,
  output logic                       lwb,
  output logic [4:0]                 lrd
);

  localparam int unsigned RW = $clog2(DEPTH);

  // Slot array state
  logic [DEPTH-1:0] slot_v_q, slot_v_d;
  logic [4:0]       slot_rd_q  [DEPTH];
  logic [4:0]       slot_rd_d  [DEPTH];
  logic [RW-1:0]    slot_rdy_q [DEPTH];
  logic [RW-1:0]    slot_rdy_d [DEPTH];

  // Long-op unit state
  logic [NREG-1:0]  pend_q, pend_d;
  logic [LATW-1:0]  cnt_q, cnt_d;
  logic [4:0]       lrd_q, lrd_d;

  // Pending table widened to the full 5-bit register space so that any
  // register number can index it even when NREG < 32.
  logic [31:0]      pend_ext;
  logic [31:0]      pend_nxt;

  // Per-source decode
  logic [4:0]       src     [2];
  logic             src_use [2];
  logic             src_pnd [2];
  logic             hit     [2];
  logic [RW-1:0]    hit_k   [2];
  logic [FW-1:0]    fwd     [2];
  logic             src_st  [2];

  logic             struct_st;
  logic             waw_st;
  logic             ins_norm;
  logic             ins_long;

  assign pend_ext   = 32'(pend_q);
  assign src[0]     = rs1;
  assign src[1]     = rs2;
  assign src_use[0] = duse1;
  assign src_use[1] = duse2;

  assign lwb   = (cnt_q == LATW'(1));
  assign lbusy = (cnt_q != '0);
  assign lrd   = lrd_q;

  // Operand hazard resolution: long-unit bypass, pending stall, then the
  // nearest slot match. A younger slot shadows older ones for the same rd.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      src_pnd[i] = pend_ext[src[i]];
      hit[i]     = 1'b0;
      hit_k[i]   = '0;
      fwd[i]     = '0;
      src_st[i]  = 1'b0;
      // Scan oldest to youngest so the lowest matching slot wins.
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (slot_v_q[k] && (slot_rd_q[k] == src[i])) begin
          hit[i]   = 1'b1;
          hit_k[i] = RW'(k);
        end
      end
      if (src_use[i] && (src[i] != 5'd0)) begin
        if (src_pnd[i] && lwb && (lrd_q == src[i])) begin
          fwd[i] = FW'(DEPTH + 1);
        end else if (src_pnd[i]) begin
          src_st[i] = 1'b1;
        end else if (hit[i]) begin
          if (hit_k[i] >= slot_rdy_q[hit_k[i]]) begin
            fwd[i] = FW'(hit_k[i]) + FW'(1);
          end else begin
            src_st[i] = 1'b1;
          end
        end
      end
    end
  end

  assign fwda = fwd[0];
  assign fwdb = fwd[1];

  // The long unit is single-issue; a new long op may only enter in the
  // writeback cycle of the previous one.
  assign struct_st = dvalid && (dlat != '0) && (cnt_q > LATW'(1));

  // A write to a register still owned by the long unit must wait for its
  // writeback so the older result cannot overwrite the younger one.
  assign waw_st = dvalid && dwreg && (rd != 5'd0) && pend_ext[rd] &&
                  !(lwb && (lrd_q == rd));

  assign stall = dvalid && !dflush &&
                 (src_st[0] || src_st[1] || struct_st || waw_st);
  assign wpcir = ~stall;
  assign issue = dvalid && !dflush && !stall;

  assign ins_norm = issue && dwreg && (rd != 5'd0) && (dlat == '0);
  assign ins_long = issue && (dlat != '0);

  // Next-state: shift the slot array, insert a bubble unless a normal
  // register write issues.
  always_comb begin
    slot_v_d      = {slot_v_q[DEPTH-2:0], ins_norm};
    slot_rd_d[0]  = ins_norm ? rd : 5'd0;
    slot_rdy_d[0] = ins_norm ? drdy : '0;
    for (int k = 1; k < DEPTH; k++) begin
      slot_rd_d[k]  = slot_rd_q[k-1];
      slot_rdy_d[k] = slot_rdy_q[k-1];
    end
  end

  // Next-state: long-op counter, destination and pending table. Clear of
  // the retiring register comes first so a new long op to the same rd
  // issued in the writeback cycle keeps its pending bit.
  always_comb begin
    cnt_d    = cnt_q;
    lrd_d    = lrd_q;
    pend_nxt = pend_ext;
    if (ins_long) begin
      cnt_d = dlat;
      lrd_d = rd;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - LATW'(1);
    end
    if (lwb) begin
      pend_nxt[lrd_q] = 1'b0;
    end
    if (ins_long && dwreg && (rd != 5'd0)) begin
      pend_nxt[rd] = 1'b1;
    end
    pend_d = pend_nxt[NREG-1:0];
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      slot_v_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        slot_rd_q[k]  <= 5'd0;
        slot_rdy_q[k] <= '0;
      end
      pend_q <= '0;
      cnt_q  <= '0;
      lrd_q  <= 5'd0;
    end else begin
      slot_v_q <= slot_v_d;
      for (int k = 0; k < DEPTH; k++) begin
        slot_rd_q[k]  <= slot_rd_d[k];
        slot_rdy_q[k] <= slot_rdy_d[k];
      end
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      lrd_q  <= lrd_d;
    end
  end

  // Internal consistency properties
  a_no_issue_on_stall : assert property (@(posedge clk) disable iff (clr)
    !(stall && issue));
  a_lwb_busy : assert property (@(posedge clk) disable iff (clr)
    lwb |-> lbusy);
  a_x0_untracked : assert property (@(posedge clk) disable iff (clr)
    !pend_q[0]);

endmodule

// File: tb/tb_pl_id_scoreboard.sv
module tb_pl_id_scoreboard;
  localparam int DEPTH = 3;
  localparam int NREG  = 32;
  localparam int LATW  = 5;
  localparam int FW    = $clog2(DEPTH + 2);
  localparam int RW    = $clog2(DEPTH);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            clr, dvalid, dflush, duse1, duse2, dwreg;
  logic [4:0]      rs1, rs2, rd;
  logic [RW-1:0]   drdy;
  logic [LATW-1:0] dlat;
  logic            stall, wpcir, issue, lbusy, lwb;
  logic [FW-1:0]   fwda, fwdb;
  logic [4:0]      lrd;

  pl_id_scoreboard #(.DEPTH(DEPTH), .NREG(NREG), .LATW(LATW), .FW(FW)) dut (
    .clk(clk), .clr(clr), .dvalid(dvalid), .dflush(dflush),
    .rs1(rs1), .rs2(rs2), .duse1(duse1), .duse2(duse2),
    .rd(rd), .dwreg(dwreg), .drdy(drdy), .dlat(dlat),
    .stall(stall), .wpcir(wpcir), .issue(issue),
    .fwda(fwda), .fwdb(fwdb), .lbusy(lbusy), .lwb(lwb), .lrd(lrd)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: per register, the cycle of its most recent normal
  // issue (age in the pipeline follows from the cycle count) plus the most
  // recent long op described by its issue cycle and latency.
  int last_cyc [NREG];
  int last_rdy [NREG];
  bit l_valid;
  int l_cyc, l_lat, l_rd;
  bit l_wreg;

  // Saved per-cycle decision applied at the following clock edge
  bit upd_clr, upd_issue, upd_w;
  int upd_d, upd_rdy, upd_lat;

  function automatic void model_reset();
    for (int r = 0; r < NREG; r++) begin
      last_cyc[r] = -100;
      last_rdy[r] = 0;
    end
    l_valid = 1'b0;
    l_cyc = 0; l_lat = 0; l_rd = 0; l_wreg = 1'b0;
  endfunction

  // Remaining long-op cycles including the current one; 1 = writeback now
  function automatic int cnt_at(int c);
    if (l_valid && c > l_cyc && c <= l_cyc + l_lat) return l_cyc + l_lat - c + 1;
    return 0;
  endfunction

  function automatic bit pend_at(int s, int c);
    return l_wreg && (l_rd == s) && (cnt_at(c) != 0);
  endfunction

  task automatic src_exp(input int s, input bit u, input int c,
                         output int fwd, output bit st);
    int age;
    fwd = 0;
    st  = 1'b0;
    if (u && s != 0) begin
      if (pend_at(s, c) && cnt_at(c) == 1) fwd = DEPTH + 1;
      else if (pend_at(s, c)) st = 1'b1;
      else begin
        age = c - last_cyc[s] - 1;
        if (age >= 0 && age < DEPTH) begin
          if (age >= last_rdy[s]) fwd = age + 1;
          else st = 1'b1;
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one ID-stage instruction, then compare every output to the model.
  task automatic cycle(input bit v, input bit fl, input int r1, input int r2,
                       input bit u1, input bit u2, input int d, input bit w,
                       input int rdy, input int lat, input bit rst);
    int fa, fb, cnt;
    bit s1, s2, lwb_e, st_e, iss_e, str_e, waw_e;
    clr = rst; dvalid = v; dflush = fl;
    rs1 = 5'(r1); rs2 = 5'(r2); duse1 = u1; duse2 = u2;
    rd = 5'(d); dwreg = w; drdy = RW'(rdy); dlat = LATW'(lat);
    #3;
    src_exp(r1, u1, cyc, fa, s1);
    src_exp(r2, u2, cyc, fb, s2);
    cnt   = cnt_at(cyc);
    lwb_e = (cnt == 1);
    str_e = v && lat != 0 && cnt > 1;
    waw_e = v && w && d != 0 && pend_at(d, cyc) && !(lwb_e && l_rd == d);
    st_e  = v && !fl && (s1 || s2 || str_e || waw_e);
    iss_e = v && !fl && !st_e;
    chk("stall", 32'(stall), 32'(st_e));
    chk("wpcir", 32'(wpcir), 32'(!st_e));
    chk("issue", 32'(issue), 32'(iss_e));
    chk("lbusy", 32'(lbusy), 32'(cnt != 0));
    chk("lwb",   32'(lwb),   32'(lwb_e));
    chk("lrd",   32'(lrd),   l_rd);
    if (!st_e) begin
      chk("fwda", 32'(fwda), fa);
      chk("fwdb", 32'(fwdb), fb);
    end else begin
      chk("fwd_known", 32'($isunknown({fwda, fwdb})), 0);
    end
    upd_clr = rst; upd_issue = iss_e; upd_w = w;
    upd_d = d; upd_rdy = rdy; upd_lat = lat;
  endtask

  task automatic nxt();
    @(posedge clk);
    if (upd_clr) model_reset();
    else if (upd_issue) begin
      if (upd_lat == 0 && upd_w && upd_d != 0) begin
        last_cyc[upd_d] = cyc;
        last_rdy[upd_d] = upd_rdy;
      end
      if (upd_lat != 0) begin
        l_valid = 1'b1; l_cyc = cyc; l_lat = upd_lat;
        l_rd = upd_d; l_wreg = upd_w && upd_d != 0;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      nxt();
    end
  endtask

  initial begin
    clr = 1'b1; dvalid = 1'b0; dflush = 1'b0; rs1 = '0; rs2 = '0;
    duse1 = 1'b0; duse2 = 1'b0; rd = '0; dwreg = 1'b0; drdy = '0; dlat = '0;
    model_reset();
    @(posedge clk);
    #1;

    // Reset state
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_wpcir", 32'(wpcir), 1);
    chk("rst_fwda", 32'(fwda), 0);
    chk("rst_fwdb", 32'(fwdb), 0);
    chk("rst_lbusy", 32'(lbusy), 0);
    chk("rst_lwb", 32'(lwb), 0);
    nxt();

    // ALU chain back-to-back
    cycle(1, 0, 1, 2, 0, 0, 5, 1, 0, 0, 0);
    chk("alu_issue", 32'(issue), 1);
    nxt();
    cycle(1, 0, 5, 5, 1, 1, 6, 1, 0, 0, 0);
    chk("alu_fwda", 32'(fwda), 1);
    chk("alu_fwdb", 32'(fwdb), 1);
    chk("alu_stall", 32'(stall), 0);
    nxt();

    // One independent op between producer and consumer
    cycle(1, 0, 1, 2, 0, 0, 5, 1, 0, 0, 0); nxt();
    cycle(1, 0, 1, 2, 0, 0, 10, 1, 0, 0, 0); nxt();
    cycle(1, 0, 5, 5, 1, 1, 6, 1, 0, 0, 0);
    chk("gap_fwda", 32'(fwda), 2);
    chk("gap_fwdb", 32'(fwdb), 2);
    nxt();

    // Load-use: one stall cycle, then forward from slot 1
    cycle(1, 0, 1, 0, 0, 0, 7, 1, 1, 0, 0); nxt();
    cycle(1, 0, 7, 0, 1, 1, 8, 1, 0, 0, 0);
    chk("lu_stall", 32'(stall), 1);
    chk("lu_wpcir", 32'(wpcir), 0);
    nxt();
    cycle(1, 0, 7, 0, 1, 1, 8, 1, 0, 0, 0);
    chk("lu_stall2", 32'(stall), 0);
    chk("lu_fwda", 32'(fwda), 2);
    chk("lu_fwdb", 32'(fwdb), 0);
    chk("lu_issue", 32'(issue), 1);
    nxt();
    idle(3);

    // Long op latency 4 with an immediate consumer
    cycle(1, 0, 0, 0, 0, 0, 9, 1, 0, 4, 0); nxt();
    for (int i = 1; i <= 3; i++) begin
      cycle(1, 0, 9, 0, 1, 0, 20, 1, 0, 0, 0);
      chk("long_stall", 32'(stall), 1);
      nxt();
    end
    cycle(1, 0, 9, 0, 1, 0, 20, 1, 0, 0, 0);
    chk("long_lwb", 32'(lwb), 1);
    chk("long_lrd", 32'(lrd), 9);
    chk("long_fwda", 32'(fwda), DEPTH + 1);
    chk("long_stall_end", 32'(stall), 0);
    nxt();
    idle(3);

    // Structural: second long op waits until the first reaches cnt==1
    cycle(1, 0, 0, 0, 0, 0, 11, 1, 0, 6, 0); nxt();
    for (int i = 1; i <= 5; i++) begin
      cycle(1, 0, 0, 0, 0, 0, 13, 1, 0, 3, 0);
      chk("struct_stall", 32'(stall), 1);
      nxt();
    end
    cycle(1, 0, 0, 0, 0, 0, 13, 1, 0, 3, 0);
    chk("struct_issue", 32'(issue), 1);
    chk("struct_lwb", 32'(lwb), 1);
    nxt();
    idle(4);

    // WAW: normal write to a pending register waits for writeback
    cycle(1, 0, 0, 0, 0, 0, 12, 1, 0, 6, 0); nxt();
    for (int i = 1; i <= 5; i++) begin
      cycle(1, 0, 0, 0, 0, 0, 12, 1, 0, 0, 0);
      chk("waw_stall", 32'(stall), 1);
      nxt();
    end
    cycle(1, 0, 0, 0, 0, 0, 12, 1, 0, 0, 0);
    chk("waw_issue", 32'(issue), 1);
    nxt();
    idle(3);

    // Flushed dependent consumer never stalls nor issues
    cycle(1, 0, 0, 0, 0, 0, 7, 1, 1, 0, 0); nxt();
    cycle(1, 1, 7, 0, 1, 0, 8, 1, 0, 0, 0);
    chk("flush_stall", 32'(stall), 0);
    chk("flush_issue", 32'(issue), 0);
    nxt();
    cycle(1, 0, 7, 0, 1, 0, 8, 1, 0, 0, 0);
    chk("flush_fwda", 32'(fwda), 2);
    nxt();
    idle(3);

    // Reset in the middle of a long op
    cycle(1, 0, 0, 0, 0, 0, 14, 1, 0, 5, 0); nxt();
    idle(2);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("rmid_busy_before", 32'(lbusy), 1);
    nxt();
    cycle(1, 0, 14, 0, 1, 0, 15, 1, 0, 0, 0);
    chk("rmid_lbusy", 32'(lbusy), 0);
    chk("rmid_stall", 32'(stall), 0);
    chk("rmid_fwda", 32'(fwda), 0);
    nxt();
    for (int i = 0; i < 6; i++) begin
      cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("rmid_no_lwb", 32'(lwb), 0);
      nxt();
    end

    // x0 is never tracked
    cycle(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0); nxt();
    cycle(1, 0, 0, 0, 1, 1, 3, 1, 0, 0, 0);
    chk("x0_fwda", 32'(fwda), 0);
    chk("x0_stall", 32'(stall), 0);
    nxt();
    cycle(1, 0, 0, 0, 0, 0, 0, 1, 0, 3, 0); nxt();
    cycle(1, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0);
    chk("x0_waw", 32'(stall), 0);
    nxt();
    idle(4);

    // Randomized traffic over a small register set to provoke hazards
    for (int n = 0; n < 4000; n++) begin
      cycle(($urandom % 8) != 0, ($urandom % 10) == 0,
            int'($urandom % 6), int'($urandom % 6),
            $urandom % 2 == 1, $urandom % 2 == 1,
            int'($urandom % 6), $urandom % 4 != 0,
            int'($urandom % DEPTH),
            (($urandom % 6) == 0) ? int'($urandom_range(1, 7)) : 0,
            ($urandom % 300) == 0);
      nxt();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pl_id_scoreboard.md
# pl_id_scoreboard

Parametrised hazard, forwarding and stall controller for the decode (ID) stage of the pipelined RISC-V core. It generalises the fixed E/M two-stage load-use interlock into a per-slot scoreboard with `DEPTH` configurable forwarding stages. It also adds a variable-latency long-operation unit (mul/div) tracked by a per-register pending table. It sits beside the ID-stage decoder and drives the ID operand-forwarding mux selects and the PC/IR write-enable.

## Interface
- `DEPTH`, default 3: pipeline slots after ID that can forward (slot 0 = E, slot 1 = M, …); minimum 2.
- `NREG`, default 32: architectural registers; register 0 is never tracked.
- `LATW`, default 5: width of long-op latency field and counter.
- `FW`, default `$clog2(DEPTH+2)`: forwarding select width.
- `clk`  in  1  clock; all state updates on rising edge.
- `clr`  in  1  reset, synchronous, active-high.
- `dvalid`  in  1  ID holds a valid instruction.
- `dflush`  in  1  instruction in ID is killed (taken branch/jump resolved upstream).
- `rs1`, `rs2`  in  5 each  source register numbers.
- `duse1`, `duse2`  in  1 each  source actually read.
- `rd`  in  5  destination register.
- `dwreg`  in  1  instruction writes `rd`.
- `drdy`  in  `$clog2(DEPTH)`  first slot index at which the result is forwardable (ALU 0, load 1).
- `dlat`  in  `LATW`  0 = normal pipeline op; L>0 = long op completing after L cycles.
- `stall`  out  1  hold PC/IR and inject a bubble into slot 0.
- `wpcir`  out  1  `~stall`.
- `issue`  out  1  `dvalid & ~dflush & ~stall`.
- `fwda`, `fwdb`  out  `FW` each  0 = regfile, k+1 = slot k result, `DEPTH+1` = long-unit result.
- `lbusy`  out  1  long unit occupied (counter ≠ 0).
- `lwb`  out  1  long-unit writeback this cycle.
- `lrd`  out  5  long-op destination.

## Operation
- Slot array `DEPTH` × {v, rd, rdy}. It shifts every cycle: slot k+1 ← slot k. The entry leaving slot `DEPTH-1` is committed; the regfile returns it from the next cycle.
- Slot 0 loads {1, `rd`, `drdy`} when `issue & dwreg & rd≠0 & dlat==0`. Otherwise slot 0 loads v=0.
- Long op (`issue & dlat≠0`):
  - Sets `cnt ← dlat` and `lrd ← rd`.
  - Sets `pend[rd]` when `dwreg & rd≠0`.
  - Does not enter the slot array.
- `cnt` decrements when non-zero. `lwb = (cnt==1)`. `pend[lrd]` clears at the end of the `lwb` cycle.
- Per source s with use bit set and s≠0, evaluated in this order:
  1. `pend[s]` and `lwb & lrd==s`: fwd = `DEPTH+1`, no stall.
  2. `pend[s]` otherwise: stall.
  3. Lowest k with slot k v & rd==s: if k ≥ slot.rdy, fwd = k+1; else stall.
  4. Otherwise fwd = 0.
- Unused source or s==0: fwd = 0 and no stall contribution.
- Structural stall: `dvalid & dlat≠0 & cnt>1`. A long op may issue in the `lwb` cycle (cnt==1).
- WAW stall: `dvalid & dwreg & rd≠0 & pend[rd] & ~(lwb & lrd==rd)`.
- `stall` = OR of all causes, gated by `dvalid & ~dflush`. A flushed instruction never stalls and never issues.
- When `stall=1`, `fwda`/`fwdb` are don't-care but must be stable (no X).

## Timing
- Reset, at the first edge with `clr=1`:
  - All slot v = 0, `pend` = 0, `cnt` = 0, `lrd` = 0.
  - Outputs: `stall`=0, `wpcir`=1, `fwda`=`fwdb`=0, `lbusy`=0, `lwb`=0.
- `clr` asserted mid long op abandons it; no `lwb` follows.
- `stall`, `fwd*`, `issue` and `lwb` are combinational from current state and ID inputs. Zero-cycle decision latency.
- Load-use with default parameters costs exactly 1 stall cycle. The load then sits in slot 1 and the consumer gets fwd=2.
- A long op of latency L issued at cycle t:
  - `lwb` at t+L.
  - A dependent consumer stalls through t+L-1 and issues at t+L with fwd=`DEPTH+1`.
- Nearest match wins. A younger slot shadows an older slot for the same rd, even if the younger one forces a stall.
- A register leaves the forwarding window one cycle after reaching slot `DEPTH-1`; fwd then returns to 0.

## Test plan
- ALU chain: `add x5` then `sub x6,x5,x5` back-to-back → fwda=fwdb=1, stall=0. With one independent op between them → fwd=2.
- Load-use: `lw x7` then `add x8,x7,x0` → stall=1 and wpcir=0 for 1 cycle, then issue with fwda=2. rs2=x0 gives fwdb=0.
- Long op: dlat=4, rd=x9, consumer of x9 next → stall 3 cycles, lwb at cycle 4 with lrd=9, consumer issues with fwda=`DEPTH+1`.
- Structural/WAW: long op (dlat=6) followed by a long op → stall until cnt==1. A normal write to the same rd during pending → stall until lwb.
- Flush: dependent load-use pair with dflush=1 on the consumer → stall=0, issue=0, slot 0 gets a bubble.
- Reset mid-op: clr during cnt=3 → next cycle lbusy=0, stall=0, fwda=0, no lwb pulse. x0 as rd/rs is never tracked or stalled.
